// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and MEM/WB operand forwarding.
// Holds one instruction; the forwarding and operand muxes are combinational from registered state.
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic [4:0]  id_rd_addr,
  input  logic [4:0]  id_alu_control,
  input  logic        id_alu_src,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic [4:0]  mem_rd_addr,
  input  logic        mem_reg_write,
  input  logic [31:0] mem_result,
  input  logic [4:0]  wb_rd_addr,
  input  logic        wb_reg_write,
  input  logic [31:0] wb_result,
  output logic        ex_valid,
  output logic [31:0] alu_rs1,
  output logic [31:0] alu_rs2,
  output logic [4:0]  alu_control,
  output logic [4:0]  ex_rd_addr,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic [31:0] ex_store_data,
  output logic        load_use_hazard
);

  typedef struct packed {
    logic        valid;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [4:0]  alu_control;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } ex_reg_t;

  ex_reg_t ex_q, ex_d;
  logic [31:0] fwd_rs1, fwd_rs2;

  assign load_use_hazard = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd_addr != 5'd0) &
                           ((ex_q.rd_addr == id_rs1_addr) | (ex_q.rd_addr == id_rs2_addr));

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (stall) begin
      ex_d = ex_q;
    end else if (load_use_hazard || !id_valid) begin
      // Bubbles are fully zeroed so nothing stale reaches the forwarding muxes.
      ex_d = '0;
    end else begin
      ex_d.valid       = 1'b1;
      ex_d.rs1_data    = id_rs1_data;
      ex_d.rs2_data    = id_rs2_data;
      ex_d.imm         = id_imm;
      ex_d.rs1_addr    = id_rs1_addr;
      ex_d.rs2_addr    = id_rs2_addr;
      ex_d.rd_addr     = id_rd_addr;
      ex_d.alu_control = id_alu_control;
      ex_d.alu_src     = id_alu_src;
      ex_d.reg_write   = id_reg_write;
      ex_d.mem_read    = id_mem_read;
      ex_d.mem_write   = id_mem_write;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // MEM beats WB; x0 is never forwarded.
  always_comb begin
    fwd_rs1 = ex_q.rs1_data;
    if (mem_reg_write && (mem_rd_addr != 5'd0) && (mem_rd_addr == ex_q.rs1_addr)) begin
      fwd_rs1 = mem_result;
    end else if (wb_reg_write && (wb_rd_addr != 5'd0) && (wb_rd_addr == ex_q.rs1_addr)) begin
      fwd_rs1 = wb_result;
    end
  end

  always_comb begin
    fwd_rs2 = ex_q.rs2_data;
    if (mem_reg_write && (mem_rd_addr != 5'd0) && (mem_rd_addr == ex_q.rs2_addr)) begin
      fwd_rs2 = mem_result;
    end else if (wb_reg_write && (wb_rd_addr != 5'd0) && (wb_rd_addr == ex_q.rs2_addr)) begin
      fwd_rs2 = wb_result;
    end
  end

  assign alu_rs1       = fwd_rs1;
  assign alu_rs2       = ex_q.alu_src ? ex_q.imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign alu_control   = ex_q.alu_control;
  assign ex_rd_addr    = ex_q.rd_addr;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_valid      = ex_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a behavioural model of the held instruction.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_control;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_result, wb_result;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;
  logic [31:0] alu_rs1, alu_rs2, ex_store_data;
  logic [4:0]  alu_control, ex_rd_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_alu_control(id_alu_control), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .ex_valid(ex_valid), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_control(alu_control),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data),
    .load_use_hazard(load_use_hazard)
  );

  // Model of the instruction sitting in EX.
  typedef struct packed {
    logic        valid;
    logic [31:0] rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd, ctl;
    logic        src, rw, mr, mw;
  } instr_t;

  instr_t m = '0;
  bit     m_live = 0;

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] own);
    if (mem_reg_write && mem_rd_addr != 0 && mem_rd_addr == a) return mem_result;
    if (wb_reg_write && wb_rd_addr != 0 && wb_rd_addr == a) return wb_result;
    return own;
  endfunction

  function automatic logic m_hazard();
    return id_valid && m.valid && m.mr && m.rd != 0 && (m.rd == id_rs1_addr || m.rd == id_rs2_addr);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m <= '0;
      m_live <= 1;
    end else if (flush || (!stall && (m_hazard() || !id_valid))) begin
      m <= '0;
    end else if (!stall) begin
      m <= '{1'b1, id_rs1_data, id_rs2_data, id_imm, id_rs1_addr, id_rs2_addr, id_rd_addr,
             id_alu_control, id_alu_src, id_reg_write, id_mem_read, id_mem_write};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (m_live) begin
      chk("m_valid", 32'(ex_valid), 32'(m.valid));
      chk("m_alu_rs1", alu_rs1, fwd(m.rs1, m.rs1_data));
      chk("m_alu_rs2", alu_rs2, m.src ? m.imm : fwd(m.rs2, m.rs2_data));
      chk("m_store", ex_store_data, fwd(m.rs2, m.rs2_data));
      chk("m_ctl", 32'(alu_control), 32'(m.ctl));
      chk("m_rd", 32'(ex_rd_addr), 32'(m.rd));
      chk("m_rw", 32'(ex_reg_write), 32'(m.rw));
      chk("m_mr", 32'(ex_mem_read), 32'(m.mr));
      chk("m_mw", 32'(ex_mem_write), 32'(m.mw));
      chk("m_hazard", 32'(load_use_hazard), 32'(m_hazard()));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    stall = 0; flush = 0; id_valid = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; id_alu_control = 0;
    id_alu_src = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    mem_rd_addr = 0; mem_reg_write = 0; mem_result = 0;
    wb_rd_addr = 0; wb_reg_write = 0; wb_result = 0;
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    step();
    step();
    #1;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_rs1", alu_rs1, 32'd0);
    chk("rst_rs2", alu_rs2, 32'd0);
    chk("rst_store", ex_store_data, 32'd0);
    chk("rst_hazard", 32'(load_use_hazard), 32'd0);
    reset = 0;

    // Basic capture
    id_valid = 1; id_rs1_data = 5; id_rs2_data = 3; id_alu_control = 5'b00001; id_rd_addr = 7;
    id_rs1_addr = 1; id_rs2_addr = 2; id_reg_write = 1;
    step(); #1;
    chk("cap_rs1", alu_rs1, 32'd5);
    chk("cap_rs2", alu_rs2, 32'd3);
    chk("cap_ctl", 32'(alu_control), 32'd1);
    chk("cap_rd", 32'(ex_rd_addr), 32'd7);
    chk("cap_valid", 32'(ex_valid), 32'd1);

    // Forwarding priority
    id_rs1_addr = 4; id_rs1_data = 32'h11;
    step();
    mem_rd_addr = 4; mem_reg_write = 1; mem_result = 32'hAA;
    wb_rd_addr = 4; wb_reg_write = 1; wb_result = 32'hBB;
    #1 chk("fwd_mem", alu_rs1, 32'hAA);
    mem_reg_write = 0;
    #1 chk("fwd_wb", alu_rs1, 32'hBB);
    id_rs1_addr = 0; id_rs1_data = 32'h22; mem_rd_addr = 0; mem_reg_write = 1;
    wb_rd_addr = 0;
    step(); #1;
    chk("fwd_x0", alu_rs1, 32'h22);
    mem_reg_write = 0; wb_reg_write = 0;

    // Load-use bubble
    id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd_addr = 9; id_rs1_addr = 1;
    id_rs2_addr = 2;
    step();
    id_mem_read = 0; id_rd_addr = 3; id_rs2_addr = 9;
    #1 chk("lu_hazard", 32'(load_use_hazard), 32'd1);
    step(); #1;
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu_bubble_rw", 32'(ex_reg_write), 32'd0);
    chk("lu_clear", 32'(load_use_hazard), 32'd0);
    step(); #1;
    chk("lu_capture_valid", 32'(ex_valid), 32'd1);
    chk("lu_capture_rd", 32'(ex_rd_addr), 32'd3);

    // Stall holds, flush beats stall
    id_rd_addr = 5; id_alu_control = 3; id_rs1_addr = 6; id_rs1_data = 32'h77;
    step();
    stall = 1; id_rd_addr = 12; id_alu_control = 9; id_rs1_data = 32'h99;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk("stall_rd", 32'(ex_rd_addr), 32'd5);
      chk("stall_ctl", 32'(alu_control), 32'd3);
      chk("stall_rs1", alu_rs1, 32'h77);
    end
    flush = 1;
    step(); #1;
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_rw", 32'(ex_reg_write), 32'd0);
    chk("flush_ctl", 32'(alu_control), 32'd0);
    stall = 0; flush = 0;

    // Immediate operand vs store data
    id_alu_src = 1; id_imm = 32'hFFFF_FFFC; id_rs2_data = 32'h1234; id_rs2_addr = 6;
    id_mem_write = 1; id_reg_write = 0;
    step(); #1;
    chk("imm_rs2", alu_rs2, 32'hFFFF_FFFC);
    chk("imm_store", ex_store_data, 32'h1234);
    id_alu_src = 0; id_mem_write = 0; id_reg_write = 1;

    // Reset overrides a stall; next edge captures normally
    stall = 1; reset = 1;
    step(); #1;
    chk("rst_mid_valid", 32'(ex_valid), 32'd0);
    chk("rst_mid_rs1", alu_rs1, 32'd0);
    chk("rst_mid_rd", 32'(ex_rd_addr), 32'd0);
    reset = 0; stall = 0; id_rd_addr = 17;
    step(); #1;
    chk("post_rst_valid", 32'(ex_valid), 32'd1);
    chk("post_rst_rd", 32'(ex_rd_addr), 32'd17);

    // Randomized traffic; small register index range keeps hazards and forwarding frequent.
    for (int n = 0; n < 3000; n++) begin
      step();
      reset = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
      id_valid = ($urandom_range(0, 5) != 0);
      id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_rs1_addr = 5'($urandom_range(0, 7)); id_rs2_addr = 5'($urandom_range(0, 7));
      id_rd_addr = 5'($urandom_range(0, 7)); id_alu_control = 5'($urandom);
      id_alu_src = 1'($urandom); id_reg_write = 1'($urandom);
      id_mem_read = ($urandom_range(0, 2) == 0); id_mem_write = 1'($urandom);
      mem_rd_addr = 5'($urandom_range(0, 7)); mem_reg_write = 1'($urandom);
      mem_result = $urandom;
      wb_rd_addr = 5'($urandom_range(0, 7)); wb_reg_write = 1'($urandom);
      wb_result = $urandom;
    end
    step();
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have inputs stall (1) and flush (1): hold request from downstream; squash request from branch/jump resolution.
REQ-004 SHALL have ID-side inputs: id_valid 1; id_rs1_data, id_rs2_data, id_imm 32 each; id_rs1_addr, id_rs2_addr, id_rd_addr 5 each; id_alu_control 5; id_alu_src, id_reg_write, id_mem_read, id_mem_write 1 each.
REQ-005 SHALL have forwarding inputs: mem_rd_addr 5, mem_reg_write 1, mem_result 32; wb_rd_addr 5, wb_reg_write 1, wb_result 32.
REQ-006 SHALL have outputs: ex_valid 1; alu_rs1, alu_rs2 32 each (ALU operand ports); alu_control 5; ex_rd_addr 5; ex_reg_write, ex_mem_read, ex_mem_write 1 each; ex_store_data 32.
REQ-007 SHALL have output load_use_hazard, 1: combinational; tells IF/ID to hold its current instruction.

Function
REQ-008 SHALL hold one instruction in a register bank (valid, rs1/rs2 data, imm, rs1/rs2/rd addr, alu_control, alu_src, reg_write, mem_read, mem_write); latency ID->EX exactly 1 cycle.
REQ-009 SHALL apply per-edge priority: reset > flush > stall > load-use bubble > capture.
REQ-010 flush=1 SHALL load a bubble (valid=0, reg_write=mem_read=mem_write=0, data/addr fields 0) regardless of stall.
REQ-011 stall=1 (no flush) SHALL hold every register unchanged.
REQ-012 load_use_hazard = id_valid & ex_valid & ex_mem_read & (ex_rd_addr!=0) & (ex_rd_addr==id_rs1_addr | ex_rd_addr==id_rs2_addr).
REQ-013 load_use_hazard=1 (no flush, no stall) SHALL load a bubble; the ID instruction is captured next cycle once the hazard clears.
REQ-014 Otherwise SHALL capture all ID inputs; id_valid=0 SHALL capture as a bubble with control bits forced 0.
REQ-015 Forwarded rs1 value: mem_result if mem_reg_write & mem_rd_addr!=0 & mem_rd_addr==registered rs1_addr; else wb_result if same condition on wb_*; else registered rs1_data. rs2 identical with rs2_addr.
REQ-016 MEM forwarding SHALL take priority over WB when both match; register x0 SHALL never be forwarded.
REQ-017 alu_rs1 SHALL equal forwarded rs1; alu_rs2 SHALL equal registered imm when alu_src=1, else forwarded rs2.
REQ-018 ex_store_data SHALL always equal forwarded rs2 (independent of alu_src).
REQ-019 alu_control, ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write, ex_valid SHALL be driven directly from registers (no combinational path from ID inputs).
REQ-020 Forwarding and operand muxes SHALL be purely combinational from registered state and current mem_*/wb_* inputs.
REQ-021 All datapaths SHALL be 32-bit with no width extension or truncation inside the block.

Reset
REQ-022 reset=1 at a rising edge SHALL zero every register: ex_valid=0, alu_control=5'b00000, ex_rd_addr=0, all control outputs 0, registered data/imm 0.
REQ-023 With registers at reset and mem/wb reg_write=0, alu_rs1, alu_rs2, ex_store_data SHALL read 0 and load_use_hazard SHALL be 0.
REQ-024 Reset asserted mid-stall or mid-hazard SHALL override both; the first post-reset edge with reset=0 SHALL capture normally.

Verification
REQ-025 Capture: id_valid=1, rs1_data=5, rs2_data=3, alu_control=00001, alu_src=0, rd=7 -> next cycle alu_rs1=5, alu_rs2=3, alu_control=00001, ex_rd_addr=7, ex_valid=1.
REQ-026 Forward priority: registered rs1_addr=4; mem_rd=4, mem_reg_write=1, mem_result=0xAA; wb_rd=4, wb_reg_write=1, wb_result=0xBB -> alu_rs1=0xAA; set mem_reg_write=0 -> alu_rs1=0xBB; rs1_addr=0 with mem_rd=0 -> alu_rs1=registered data.
REQ-027 Load-use: EX holds mem_read=1, rd=9; ID id_valid=1, rs2_addr=9 -> load_use_hazard=1, next cycle ex_valid=0, ex_reg_write=0; following cycle (hazard clear) ID instruction captured.
REQ-028 Stall vs flush: valid instruction held under stall=1 for 3 cycles -> outputs unchanged; stall=1 and flush=1 same edge -> ex_valid=0, control outputs 0.
REQ-029 Immediate/store: alu_src=1, imm=0xFFFFFFFC, rs2_data=0x1234 -> alu_rs2=0xFFFFFFFC, ex_store_data=0x1234.
REQ-030 Reset mid-operation: valid instruction in stage, reset=1 one edge -> all outputs 0, ex_valid=0.
